// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO playback controller: state codes and data width.
package fifo_ctrl_pkg;

  localparam int FIFO_DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t HOLD  = 2'd3;

  localparam logic [4:0] PCOUNT_MAX = 5'd31;

endpackage

// File: rtl/fifo_playback_ctrl_timer.sv
// Display hold timer: loaded on capture, pulses expire in the last hold cycle.
module playback_timer
  import fifo_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic CLK100,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  // Counts remaining cycles down; zero corresponds to elapsed count HOLD_CYCLES-1.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK100 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(HOLD_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/fifo_playback_ctrl.sv
// Read-side sequencer for the playback FIFO: timed or single-step pops into a
// display register for the LED bank.
//   state | meaning
//   IDLE  | waiting for start or step
//   ISSUE | one cycle, pop request when FIFO not empty
//   WAIT  | RD_LATENCY cycles until read data is valid, capture on the last
//   HOLD  | byte on display for HOLD_CYCLES cycles
module fifo_playback_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W      = FIFO_DATA_W,
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27,
  parameter int RD_LATENCY  = 1
) (
  input  logic              CLK100,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_request,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  output logic              busy,
  output logic [4:0]        played_count,
  output logic              done
);

  localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  state_t            state;
  state_t            state_nxt;
  logic              stop_pending;
  logic              step_mode;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;
  logic              hold_expire;

  assign fifo_rd_request = (state == ISSUE) && !fifo_empty;
  assign busy            = (state != IDLE);
  assign wait_last       = (state == WAIT) && (wait_cnt == '0);

  playback_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .CLK100(CLK100),
    .reset (reset),
    .load  (wait_last),
    .en    (state == HOLD),
    .expire(hold_expire)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!stop && (start || step)) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = fifo_empty ? IDLE : WAIT;
      end
      WAIT: begin
        // A stop seen during the pop still lets the popped byte land first.
        if (wait_last) state_nxt = (step_mode || stop_pending || stop) ? IDLE : HOLD;
      end
      HOLD: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (hold_expire) begin
          state_nxt = (stop_pending || fifo_empty) ? IDLE : ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK100 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      done         <= 1'b0;
      stop_pending <= 1'b0;
      step_mode    <= 1'b0;
      wait_cnt     <= '0;
      disp_data    <= '0;
      disp_valid   <= 1'b0;
      played_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state != IDLE) && (state_nxt == IDLE);

      if (state_nxt == IDLE) begin
        stop_pending <= 1'b0;
      end else if (stop && ((state == ISSUE) || (state == WAIT))) begin
        stop_pending <= 1'b1;
      end

      if ((state == IDLE) && !stop) begin
        if (start) begin
          step_mode    <= 1'b0;
          played_count <= '0;
        end else if (step) begin
          step_mode <= 1'b1;
        end
      end

      if (fifo_rd_request) begin
        wait_cnt <= WAIT_W'(RD_LATENCY - 1);
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end

      if (wait_last) begin
        disp_data  <= fifo_rd_data;
        disp_valid <= 1'b1;
        if (played_count != PCOUNT_MAX) played_count <= played_count + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_playback_ctrl.sv
// Bench for fifo_playback_ctrl: queue-based FIFO, event monitor and a timing
// model derived from the pop-period rules.
module tb_fifo_playback_ctrl;

  localparam int H = 4;
  localparam int P = H + 2;

  logic       CLK100 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       step = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_request;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       busy;
  logic [4:0] played_count;
  logic       done;

  int total = 0;
  int bad = 0;

  always #5 CLK100 = ~CLK100;

  fifo_playback_ctrl #(
    .DATA_W(8), .HOLD_CYCLES(H), .CNT_W(4), .RD_LATENCY(1)
  ) dut (
    .CLK100(CLK100), .reset(reset), .start(start), .stop(stop), .step(step),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_request(fifo_rd_request), .disp_data(disp_data),
    .disp_valid(disp_valid), .busy(busy), .played_count(played_count), .done(done)
  );

  // FIFO model, one-cycle read latency
  logic       wr_en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fq[$];
  int         fifo_errs = 0;

  always @(posedge CLK100) begin
    if (fifo_rd_request === 1'b1) begin
      if (fq.size() == 0) fifo_errs <= fifo_errs + 1;
      else fifo_rd_data <= fq.pop_front();
    end
    if (flush) fq.delete();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  // Event monitor: request, done and capture cycles
  int         cyc = 0;
  int         prev_pc = 0;
  int         req_q[$];
  int         done_q[$];
  int         cap_cyc[$];
  logic [7:0] cap_dat[$];

  always @(posedge CLK100) cyc <= cyc + 1;

  always @(negedge CLK100) begin
    if (fifo_rd_request === 1'b1) req_q.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
    if (int'(played_count) == prev_pc + 1) begin
      cap_cyc.push_back(cyc);
      cap_dat.push_back(disp_data);
    end
    prev_pc <= int'(played_count);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: pop k issues k*P cycles after ISSUE starts; a stop in hold
  // cycle h of pop j ends the run one cycle later; an empty FIFO ends it after ISSUE.
  function automatic void model_play(input int n, input int stop_after, input int stop_h,
                                     output int n_pops, output int done_rel);
    if (n == 0) begin
      n_pops = 0; done_rel = 1;
    end else if (stop_after >= 0 && stop_after < n) begin
      n_pops = stop_after + 1; done_rel = stop_after * P + 2 + stop_h;
    end else begin
      n_pops = n; done_rel = n * P;
    end
  endfunction

  task automatic pulse_at(input int which, input int target);
    while (cyc < target) @(negedge CLK100);
    case (which)
      0: start = 1'b1;
      1: stop = 1'b1;
      default: step = 1'b1;
    endcase
    @(negedge CLK100);
    start = 1'b0; stop = 1'b0; step = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge CLK100); wr_en = 1'b1; wr_data = b;
    @(negedge CLK100); wr_en = 1'b0;
  endtask

  task automatic flush_fifo();
    @(negedge CLK100); flush = 1'b1;
    @(negedge CLK100); flush = 1'b0;
    @(negedge CLK100);
  endtask

  task automatic wait_done(input int n0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge CLK100); #1;
      if (done_q.size() > n0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge CLK100); #1;
    total++; if ({fifo_rd_request, disp_valid, busy, done} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {fifo_rd_request, disp_valid, busy, done}); end
    total++; if (disp_data !== 8'h00) begin bad++; $display("FAIL reset_disp_data: got %h want 00", disp_data); end
    total++; if (played_count !== 5'd0) begin bad++; $display("FAIL reset_played_count: got %0d want 0", played_count); end
    repeat (3) @(negedge CLK100);
    #1;
    total++; if ({fifo_rd_request, disp_valid, busy, done, disp_data, played_count} !== 17'b0) begin bad++; $display("FAIL reset_hold: got %h want 0", {fifo_rd_request, disp_valid, busy, done, disp_data, played_count}); end
    @(negedge CLK100); reset = 1'b0;
  endtask

  task automatic test_playback();
    logic [7:0] d[3];
    int r0, c0, d0, ts, n_pops, done_rel, got;
    logic [7:0] gd;
    bit ok;
    d[0] = 8'hA1; d[1] = 8'hB2; d[2] = 8'hC3;
    flush_fifo();
    for (int i = 0; i < 3; i++) write_byte(d[i]);
    model_play(3, -1, 0, n_pops, done_rel);
    r0 = req_q.size(); c0 = cap_cyc.size(); d0 = done_q.size();
    ts = cyc + 1; pulse_at(0, cyc);
    pulse_at(2, ts + 3);      // step while busy must be ignored
    pulse_at(0, ts + P + 3);  // as must a second start
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL playback_busy_mid: got %b want 1", busy); end
    wait_done(d0, 40, ok);
    total++; if (!ok) begin bad++; $display("FAIL playback_done_timeout: got none want done within 40 cycles"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL playback_busy_at_done: got %b want 0", busy); end
    total++; if (req_q.size() - r0 !== n_pops) begin bad++; $display("FAIL playback_req_count: got %0d want %0d", req_q.size() - r0, n_pops); end
    for (int k = 0; k < n_pops; k++) begin
      got = (r0 + k < req_q.size()) ? req_q[r0 + k] - ts : -1;
      total++; if (got !== k * P) begin bad++; $display("FAIL playback_req_time[%0d]: got +%0d want +%0d", k, got, k * P); end
      gd = (c0 + k < cap_dat.size()) ? cap_dat[c0 + k] : 8'hxx;
      total++; if (gd !== d[k]) begin bad++; $display("FAIL playback_disp[%0d]: got %h want %h", k, gd, d[k]); end
      got = (c0 + k < cap_cyc.size()) ? cap_cyc[c0 + k] - ts : -1;
      total++; if (got !== k * P + 2) begin bad++; $display("FAIL playback_cap_time[%0d]: got +%0d want +%0d", k, got, k * P + 2); end
    end
    got = (d0 < done_q.size()) ? done_q[d0] - ts : -1;
    total++; if (got !== done_rel) begin bad++; $display("FAIL playback_done_time: got +%0d want +%0d", got, done_rel); end
    total++; if (played_count !== 5'd3) begin bad++; $display("FAIL playback_count: got %0d want 3", played_count); end
    repeat (3) @(negedge CLK100);
    total++; if (done_q.size() - d0 !== 1) begin bad++; $display("FAIL playback_done_once: got %0d want 1", done_q.size() - d0); end
  endtask

  task automatic test_empty_start();
    int r0, d0, ts, got;
    bit ok;
    flush_fifo();
    r0 = req_q.size(); d0 = done_q.size();
    ts = cyc + 1; pulse_at(0, cyc);
    wait_done(d0, 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL empty_done_timeout: got none want done within 10 cycles"); end
    got = (d0 < done_q.size()) ? done_q[d0] - ts : -1;
    total++; if (got !== 1) begin bad++; $display("FAIL empty_done_time: got +%0d want +1", got); end
    total++; if (req_q.size() !== r0) begin bad++; $display("FAIL empty_no_request: got %0d want 0", req_q.size() - r0); end
    total++; if (played_count !== 5'd0) begin bad++; $display("FAIL empty_count_cleared: got %0d want 0", played_count); end
  endtask

  task automatic test_stop_hold();
    int r0, d0, ts, got, n_pops, done_rel;
    bit ok;
    flush_fifo();
    write_byte(8'h10); write_byte(8'h20); write_byte(8'h30);
    model_play(3, 0, 2, n_pops, done_rel);
    r0 = req_q.size(); d0 = done_q.size();
    ts = cyc + 1; pulse_at(0, cyc);
    pulse_at(1, ts + 1 + 2);
    wait_done(d0, 30, ok);
    total++; if (!ok) begin bad++; $display("FAIL stop_hold_timeout: got none want done within 30 cycles"); end
    got = (d0 < done_q.size()) ? done_q[d0] - ts : -1;
    total++; if (got !== done_rel) begin bad++; $display("FAIL stop_hold_done_time: got +%0d want +%0d", got, done_rel); end
    total++; if (req_q.size() - r0 !== n_pops) begin bad++; $display("FAIL stop_hold_req_count: got %0d want %0d", req_q.size() - r0, n_pops); end
    total++; if (disp_data !== 8'h10) begin bad++; $display("FAIL stop_hold_disp: got %h want 10", disp_data); end
    total++; if (fq.size() !== 2) begin bad++; $display("FAIL stop_hold_fifo_left: got %0d want 2", fq.size()); end
  endtask

  task automatic test_step();
    logic [7:0] exp_d[3];
    int exp_req[3], exp_done[3];
    int r0, d0, ts, got;
    bit ok;
    exp_d[0] = 8'h55; exp_d[1] = 8'h66; exp_d[2] = 8'h66;
    exp_req[0] = 1; exp_req[1] = 1; exp_req[2] = 0;
    exp_done[0] = 2; exp_done[1] = 2; exp_done[2] = 1;
    flush_fifo();
    write_byte(8'h55); write_byte(8'h66);
    for (int s = 0; s < 3; s++) begin
      r0 = req_q.size(); d0 = done_q.size();
      ts = cyc + 1; pulse_at(2, cyc);
      wait_done(d0, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL step_timeout[%0d]: got none want done within 10 cycles", s); end
      got = (d0 < done_q.size()) ? done_q[d0] - ts : -1;
      total++; if (got !== exp_done[s]) begin bad++; $display("FAIL step_done_time[%0d]: got +%0d want +%0d", s, got, exp_done[s]); end
      total++; if (req_q.size() - r0 !== exp_req[s]) begin bad++; $display("FAIL step_req_count[%0d]: got %0d want %0d", s, req_q.size() - r0, exp_req[s]); end
      total++; if (disp_data !== exp_d[s]) begin bad++; $display("FAIL step_disp[%0d]: got %h want %h", s, disp_data, exp_d[s]); end
      total++; if (fq.size() !== 1 - s + (s == 2 ? 1 : 0)) begin bad++; $display("FAIL step_fifo_left[%0d]: got %0d want %0d", s, fq.size(), 1 - s + (s == 2 ? 1 : 0)); end
    end
    // step does not clear the count; it continues from the single pop of the stop test
    total++; if (played_count !== 5'd3) begin bad++; $display("FAIL step_count: got %0d want 3", played_count); end
  endtask

  task automatic test_stop_issue_reset();
    logic [7:0] b0, b1;
    int r0, c0, d0, ts, got;
    bit ok;
    b0 = 8'($urandom); b1 = 8'($urandom);
    flush_fifo();
    write_byte(b0); write_byte(b1);
    r0 = req_q.size(); c0 = cap_cyc.size(); d0 = done_q.size();
    ts = cyc + 1; pulse_at(0, cyc);
    pulse_at(1, cyc);
    wait_done(d0, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL stop_issue_timeout: got none want done within 20 cycles"); end
    got = (d0 < done_q.size()) ? done_q[d0] - ts : -1;
    total++; if (got !== 2) begin bad++; $display("FAIL stop_issue_done_time: got +%0d want +2", got); end
    total++; if (req_q.size() - r0 !== 1) begin bad++; $display("FAIL stop_issue_req_count: got %0d want 1", req_q.size() - r0); end
    total++; if (disp_data !== b0) begin bad++; $display("FAIL stop_issue_disp: got %h want %h", disp_data, b0); end
    total++; if (fq.size() !== 1) begin bad++; $display("FAIL stop_issue_fifo_left: got %0d want 1", fq.size()); end
    ts = cyc + 1; pulse_at(0, cyc);
    @(negedge CLK100);
    #1 reset = 1'b1;
    #1;
    total++; if ({disp_valid, fifo_rd_request, busy, done} !== 4'b0) begin bad++; $display("FAIL reset_wait_flags: got %b want 0000", {disp_valid, fifo_rd_request, busy, done}); end
    total++; if ({disp_data, played_count} !== 13'b0) begin bad++; $display("FAIL reset_wait_data: got %h want 0", {disp_data, played_count}); end
    @(negedge CLK100); reset = 1'b0;
    repeat (3) @(negedge CLK100);
    total++; if (fq.size() !== 0) begin bad++; $display("FAIL reset_wait_byte_lost: got %0d left want 0", fq.size()); end
    total++; if (cap_cyc.size() - c0 !== 1) begin bad++; $display("FAIL reset_wait_no_capture: got %0d captures want 1", cap_cyc.size() - c0); end
  endtask

  task automatic test_random_playback();
    logic [7:0] d[$];
    int n, sa, sh, n_pops, done_rel, r0, c0, d0, ts, got;
    logic [7:0] gd;
    bit ok;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 4));
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      sh = int'($urandom_range(1, H));
      flush_fifo();
      d.delete();
      for (int i = 0; i < n; i++) begin
        d.push_back(8'($urandom));
        write_byte(d[i]);
      end
      model_play(n, sa, sh, n_pops, done_rel);
      r0 = req_q.size(); c0 = cap_cyc.size(); d0 = done_q.size();
      ts = cyc + 1; pulse_at(0, cyc);
      if (sa >= 0) pulse_at(1, ts + sa * P + 1 + sh);
      wait_done(d0, n * P + 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL rand_timeout[%0d]: got none want done within %0d cycles", it, n * P + 10); end
      total++; if (req_q.size() - r0 !== n_pops) begin bad++; $display("FAIL rand_req_count[%0d]: got %0d want %0d", it, req_q.size() - r0, n_pops); end
      for (int k = 0; k < n_pops; k++) begin
        got = (r0 + k < req_q.size()) ? req_q[r0 + k] - ts : -1;
        total++; if (got !== k * P) begin bad++; $display("FAIL rand_req_time[%0d.%0d]: got +%0d want +%0d", it, k, got, k * P); end
        gd = (c0 + k < cap_dat.size()) ? cap_dat[c0 + k] : 8'hxx;
        total++; if (gd !== d[k]) begin bad++; $display("FAIL rand_disp[%0d.%0d]: got %h want %h", it, k, gd, d[k]); end
      end
      got = (d0 < done_q.size()) ? done_q[d0] - ts : -1;
      total++; if (got !== done_rel) begin bad++; $display("FAIL rand_done_time[%0d]: got +%0d want +%0d", it, got, done_rel); end
      total++; if (played_count !== 5'(n_pops)) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, played_count, n_pops); end
      total++; if (fq.size() !== n - n_pops) begin bad++; $display("FAIL rand_fifo_left[%0d]: got %0d want %0d", it, fq.size(), n - n_pops); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_busy[%0d]: got %b want 0", it, busy); end
    end
  endtask

  task automatic test_saturation();
    int d0;
    bit ok;
    flush_fifo();
    for (int i = 0; i < 33; i++) begin
      if (i % 16 == 0) begin
        for (int j = 0; j < 16 && i + j < 33; j++) write_byte(8'(i + j + 1));
      end
      d0 = done_q.size();
      pulse_at(2, cyc);
      wait_done(d0, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL sat_step_timeout[%0d]: got none want done within 10 cycles", i); end
      if (i == 30) begin
        total++; if (played_count !== 5'd31) begin bad++; $display("FAIL sat_count_31: got %0d want 31", played_count); end
      end
    end
    total++; if (played_count !== 5'd31) begin bad++; $display("FAIL sat_count_held: got %0d want 31", played_count); end
    total++; if (disp_data !== 8'd33) begin bad++; $display("FAIL sat_disp: got %h want 21", disp_data); end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_empty_start();
    test_stop_hold();
    test_step();
    test_stop_issue_reset();
    test_saturation();
    test_random_playback();
    total++; if (fifo_errs !== 0) begin bad++; $display("FAIL request_while_empty: got %0d want 0", fifo_errs); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_playback_ctrl.md
Name: fifo_playback_ctrl

Overview:
Read-side sequencer for the 16-entry x 8-bit synchronous FIFO. On a start pulse it drains the FIFO one byte at a time at a programmable rate. It issues single-cycle rd_request pulses and latches each popped byte into a display register for the LED bank. It also supports single-step reads, and it stops cleanly on stop or when the FIFO runs empty.

Parameters:
DATA_W, 8, FIFO data width.
HOLD_CYCLES, 100_000_000, number of cycles each byte is displayed (1 s at 100 MHz); must be >= 1.
CNT_W, 27, hold counter width; must satisfy 2**CNT_W > HOLD_CYCLES.
RD_LATENCY, 1, cycles from fifo_rd_request high to fifo_rd_data valid; must be >= 1.

Ports:
CLK100  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-high.
start  in  1  single-cycle pulse (already debounced and edge-detected): begin continuous playback.
stop  in  1  single-cycle pulse: end playback.
step  in  1  single-cycle pulse: pop and display exactly one byte.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_data  in  DATA_W  FIFO read data.
fifo_rd_request  out  1  single-cycle pop request to the FIFO.
disp_data  out  DATA_W  last byte popped.
disp_valid  out  1  high once any byte has been captured since reset.
busy  out  1  high in any state other than IDLE.
played_count  out  5  bytes popped since the last start; saturates at 31.
done  out  1  single-cycle pulse when a playback or step sequence ends.

Behaviour:
- Reset values: all outputs 0; state IDLE; hold counter 0; stop_pending 0; step_mode 0.
- States: IDLE, ISSUE, WAIT, HOLD.
- fifo_rd_request = (state == ISSUE) && !fifo_empty. It is a Moore-style output with no combinational path from start, stop or step.
- IDLE:
  - stop has priority over start and step, and leaves the controller in IDLE.
  - start: clear played_count, step_mode=0 -> ISSUE.
  - step (no start): step_mode=1 -> ISSUE.
  - start and step together: start wins.
- ISSUE (one cycle):
  - If fifo_empty: no request; done pulses next cycle -> IDLE.
  - Else request is asserted -> WAIT.
- WAIT: lasts RD_LATENCY cycles. At the end of the last WAIT cycle:
  - disp_data <= fifo_rd_data; disp_valid <= 1; played_count++ (saturating at 31).
  - If step_mode: -> IDLE with done.
  - Else -> HOLD.
- HOLD: lasts HOLD_CYCLES cycles, then:
  - stop_pending or fifo_empty -> IDLE with done.
  - Otherwise -> ISSUE.
- stop handling:
  - During HOLD: -> IDLE next cycle with done. disp_data is retained.
  - During ISSUE or WAIT: set stop_pending. The byte already popped is still captured, so no data is lost, then -> IDLE with done.
- stop_pending clears on entry to IDLE.
- start and step are ignored while busy.
- Timing (RD_LATENCY=1), with start sampled at edge t:
  - ISSUE during cycle t+1, request high.
  - WAIT during t+2; disp_data updates at edge t+3.
  - HOLD spans t+3 .. t+2+HOLD_CYCLES.
  - Next ISSUE at t+3+HOLD_CYCLES, giving a pop period of HOLD_CYCLES+2.
- done: registered, asserted for exactly the one cycle in which state == IDLE is first entered from a non-IDLE state.
- Reset mid-operation: immediate return to reset values. Any in-flight pop is abandoned and its byte is lost.
- Never more than one outstanding request. The controller never requests while fifo_empty=1.

Decomposition:
- Package fifo_ctrl_pkg holds the state enum (IDLE, ISSUE, WAIT, HOLD) and the DATA_W default constant.
- One sub-module, playback_timer (parameters HOLD_CYCLES, CNT_W):
  - Inputs: load, en.
  - Output: expire, a one-cycle pulse when the count reaches HOLD_CYCLES-1.
- The WAIT latency counter stays inline.

Test Plan:
1. Reset check -> all outputs 0. Assert reset for 3 cycles -> outputs stay 0 and state stays IDLE.
2. HOLD_CYCLES=4; write 0xA1, 0xB2, 0xC3; pulse start -> three rd_request pulses spaced 6 cycles apart. disp_data steps A1 -> B2 -> C3. played_count=3. done fires after the HOLD following C3. busy falls the same cycle.
3. FIFO empty; pulse start -> no rd_request; done pulse 2 cycles after start; played_count=0.
4. Write 0x10, 0x20, 0x30; start; pulse stop in the 2nd HOLD cycle after 0x10 -> IDLE next cycle with done. disp_data=0x10. FIFO still holds 0x20 and 0x30.
5. Write 0x55, 0x66; step -> single pop, disp_data=0x55, done, FIFO holds 0x66. step again -> 0x66. A third step with FIFO empty -> no request; done.
6. Start with 2 entries; pulse stop in the ISSUE cycle -> byte still captured, then IDLE/done. Assert reset during WAIT -> disp_data=0, disp_valid=0, fifo_rd_request=0 immediately.
